// File: rtl/dma_port_model_if.sv
// Engine-facing handshake of the DMA port model: read beat stream out, result drain in.
interface dma_port_model_if #(
    parameter int DATA_W = 16
) ();
    logic              reads_en;
    logic              ob_we;
    logic [DATA_W-1:0] ob_data;
    logic              writes_en;
    logic              ib_re;
    logic              ib_valid;
    logic [DATA_W-1:0] ib_data;

    // master = engine side, slave = the port model
    modport master (
        output reads_en, writes_en, ib_valid, ib_data,
        input  ob_we, ob_data, ib_re
    );
    modport slave (
        input  reads_en, writes_en, ib_valid, ib_data,
        output ob_we, ob_data, ib_re
    );
endinterface

// File: rtl/dma_port_model.sv
// DMA port responder: local memory streamed to the engine with programmable cadence
// and sliding-window rewind; engine results drained back into the same memory.
module dma_port_model #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_rd_base,
    input  logic [ADDR_W-1:0] cfg_win_len,
    input  logic [ADDR_W-1:0] cfg_win_step,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    dma_port_model_if.slave   bus,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              wr_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [GAP_W-1:0]  G_ONE = GAP_W'(1);
    localparam logic [15:0]       C_ONE = 16'd1;
    localparam logic [15:0]       C_MAX = 16'hFFFF;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] rd_ptr, win_start, win_cnt, wr_ptr;
    logic [ADDR_W-1:0] win_len_q, win_step_q;
    logic [GAP_W-1:0]  gap_q, rph, wph;
    logic              capture;

    // A preload on the same edge always wins the write port
    always_comb begin
        capture = bus.ib_valid && !rst && !cfg_valid && !ld_we;
    end

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end else if (capture) begin
            mem[wr_ptr] <= bus.ib_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ob_we   <= 1'b0;
            bus.ob_data <= '0;
            bus.ib_re   <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
            wr_err      <= 1'b0;
            rd_ptr      <= '0;
            win_start   <= '0;
            win_cnt     <= '0;
            wr_ptr      <= '0;
            win_len_q   <= '0;
            win_step_q  <= '0;
            gap_q       <= '0;
            rph         <= '0;
            wph         <= '0;
        end else if (cfg_valid) begin
            bus.ob_we  <= 1'b0;
            bus.ib_re  <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
            wr_err     <= 1'b0;
            rd_ptr     <= cfg_rd_base;
            win_start  <= cfg_rd_base;
            win_cnt    <= '0;
            wr_ptr     <= cfg_wr_base;
            win_len_q  <= cfg_win_len;
            win_step_q <= cfg_win_step;
            gap_q      <= cfg_gap;
            rph        <= '0;
            wph        <= '0;
        end else begin
            bus.ob_we <= 1'b0;
            bus.ib_re <= 1'b0;

            if (bus.reads_en) begin
                if (rph == gap_q) begin
                    rph         <= '0;
                    bus.ob_we   <= 1'b1;
                    bus.ob_data <= mem[rd_ptr];
                    if (rd_count != C_MAX) rd_count <= rd_count + C_ONE;
                    if (win_len_q == '0) begin
                        rd_ptr <= rd_ptr + A_ONE;
                    end else if (win_cnt == win_len_q - A_ONE) begin
                        // Rewind to the advanced window start
                        win_start <= win_start + win_step_q;
                        rd_ptr    <= win_start + win_step_q;
                        win_cnt   <= '0;
                    end else begin
                        rd_ptr  <= rd_ptr + A_ONE;
                        win_cnt <= win_cnt + A_ONE;
                    end
                end else begin
                    rph <= rph + G_ONE;
                end
            end

            if (bus.writes_en) begin
                if (wph == gap_q) begin
                    wph       <= '0;
                    bus.ib_re <= 1'b1;
                end else begin
                    wph <= wph + G_ONE;
                end
            end

            if (bus.ib_valid) begin
                if (ld_we) begin
                    wr_err <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + A_ONE;
                    if (wr_count != C_MAX) wr_count <= wr_count + C_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_port_model.sv
// Self-checking bench for dma_port_model against a cycle-count/address-formula reference model.
module tb_dma_port_model;
    logic        clk = 1'b0;
    logic        rst, cfg_valid, ld_we;
    logic [9:0]  cfg_rd_base, cfg_win_len, cfg_win_step, cfg_wr_base, ld_addr;
    logic [3:0]  cfg_gap;
    logic [15:0] ld_data, rd_count, wr_count;
    logic        wr_err;

    dma_port_model_if #(.DATA_W(16)) bus ();

    dma_port_model #(.DATA_W(16), .ADDR_W(10), .GAP_W(4)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid),
        .cfg_rd_base(cfg_rd_base), .cfg_win_len(cfg_win_len), .cfg_win_step(cfg_win_step),
        .cfg_wr_base(cfg_wr_base), .cfg_gap(cfg_gap),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .bus(bus), .rd_count(rd_count), .wr_count(wr_count), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory image plus counts of enabled cycles and beats since config
    logic [15:0] shadow [1024];
    int m_base, m_len, m_step, m_gap, m_wrbase;
    int m_ren, m_k, m_wen, m_wn;
    bit m_err;
    bit e_ob_we, e_ib_re, e_err;
    logic [15:0] e_ob_data, e_rd, e_wr;

    function automatic int beat_addr(int k);
        if (m_len == 0) return (m_base + k) & 1023;
        return (m_base + (k / m_len) * m_step + (k % m_len)) & 1023;
    endfunction

    task automatic model_clear();
        m_ren = 0; m_k = 0; m_wen = 0; m_wn = 0; m_err = 0;
        e_ob_we = 0; e_ib_re = 0;
    endtask

    // Predict this edge from the current inputs, then advance the clock and settle
    task automatic tick();
        bit fr, fw;
        fr = 0; fw = 0;
        if (rst) begin
            m_base = 0; m_len = 0; m_step = 0; m_gap = 0; m_wrbase = 0;
            model_clear();
            e_ob_data = '0;
        end else if (cfg_valid) begin
            m_base = int'(cfg_rd_base); m_len = int'(cfg_win_len); m_step = int'(cfg_win_step);
            m_gap = int'(cfg_gap); m_wrbase = int'(cfg_wr_base);
            model_clear();
        end else begin
            if (bus.reads_en) begin
                fr = (m_ren % (m_gap + 1)) == m_gap;
                m_ren++;
            end
            if (fr) begin
                e_ob_data = shadow[10'(beat_addr(m_k))];
                m_k++;
            end
            if (bus.writes_en) begin
                fw = (m_wen % (m_gap + 1)) == m_gap;
                m_wen++;
            end
            e_ob_we = fr;
            e_ib_re = fw;
            if (bus.ib_valid) begin
                if (ld_we) m_err = 1;
                else begin
                    shadow[10'((m_wrbase + m_wn) & 1023)] = bus.ib_data;
                    m_wn++;
                end
            end
        end
        if (ld_we) shadow[ld_addr] = ld_data;
        e_rd  = (m_k  > 65535) ? 16'hFFFF : 16'(m_k);
        e_wr  = (m_wn > 65535) ? 16'hFFFF : 16'(m_wn);
        e_err = m_err;
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [9:0] rb, input logic [9:0] wl, input logic [9:0] ws,
                             input logic [9:0] wb, input logic [3:0] g);
        cfg_rd_base = rb; cfg_win_len = wl; cfg_win_step = ws; cfg_wr_base = wb; cfg_gap = g;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (bus.ob_we !== 1'b0) begin n_errors++; $display("FAIL reset_ob_we got %b want 0", bus.ob_we); end
        n_checks++; if (bus.ob_data !== 16'h0) begin n_errors++; $display("FAIL reset_ob_data got %h want 0", bus.ob_data); end
        n_checks++; if (bus.ib_re !== 1'b0) begin n_errors++; $display("FAIL reset_ib_re got %b want 0", bus.ib_re); end
        n_checks++; if (rd_count !== 16'h0) begin n_errors++; $display("FAIL reset_rd_count got %0d want 0", rd_count); end
        n_checks++; if (wr_count !== 16'h0) begin n_errors++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
        n_checks++; if (wr_err !== 1'b0) begin n_errors++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
    endtask

    task automatic preload_all();
        for (int i = 0; i < 1024; i++) begin
            ld_we = 1'b1;
            ld_addr = 10'(i);
            ld_data = (i < 64) ? 16'(16'h3C00 + i) : 16'($urandom);
            tick();
        end
        ld_we = 1'b0;
    endtask

    task automatic test_linear();
        int nb;
        nb = 0;
        configure(10'h000, 10'd0, 10'd0, 10'h000, 4'd2);
        bus.reads_en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_checks++; if (bus.ob_we !== e_ob_we) begin n_errors++; $display("FAIL linear_ob_we cyc %0d got %b want %b", c, bus.ob_we, e_ob_we); end
            if (e_ob_we) begin
                n_checks++; if (bus.ob_data !== 16'(16'h3C00 + nb)) begin n_errors++; $display("FAIL linear_data beat %0d got %h want %h", nb, bus.ob_data, 16'(16'h3C00 + nb)); end
                nb++;
            end
        end
        n_checks++; if (rd_count !== 16'd10) begin n_errors++; $display("FAIL linear_rd_count got %0d want 10", rd_count); end
        bus.reads_en = 1'b0;
    endtask

    task automatic test_window();
        int nb;
        nb = 0;
        configure(10'h000, 10'd45, 10'd1, 10'h000, 4'd2);
        bus.reads_en = 1'b1;
        for (int c = 0; c < 3 * 45 * 3; c++) begin
            tick();
            n_checks++; if (bus.ob_we !== e_ob_we) begin n_errors++; $display("FAIL window_ob_we cyc %0d got %b want %b", c, bus.ob_we, e_ob_we); end
            if (e_ob_we) begin
                // window w covers addresses w..w+44, preloaded with 3C00+addr
                n_checks++; if (bus.ob_data !== 16'(16'h3C00 + nb / 45 + nb % 45)) begin n_errors++; $display("FAIL window_data beat %0d got %h want %h", nb, bus.ob_data, 16'(16'h3C00 + nb / 45 + nb % 45)); end
                nb++;
            end
        end
        n_checks++; if (rd_count !== 16'd135) begin n_errors++; $display("FAIL window_rd_count got %0d want 135", rd_count); end
        bus.reads_en = 1'b0;
    endtask

    task automatic test_pause();
        configure(10'h008, 10'd0, 10'd0, 10'h000, 4'd2);
        for (int c = 0; c < 37; c++) begin
            bus.reads_en = (c >= 10 && c < 17) ? 1'b0 : 1'b1;
            tick();
            n_checks++; if (bus.ob_we !== e_ob_we) begin n_errors++; $display("FAIL pause_ob_we cyc %0d got %b want %b", c, bus.ob_we, e_ob_we); end
            n_checks++; if (bus.ob_data !== e_ob_data) begin n_errors++; $display("FAIL pause_ob_data cyc %0d got %h want %h", c, bus.ob_data, e_ob_data); end
        end
        n_checks++; if (rd_count !== 16'd10) begin n_errors++; $display("FAIL pause_rd_count got %0d want 10", rd_count); end
        bus.reads_en = 1'b0;
    endtask

    task automatic test_drain();
        int sent, nb;
        sent = 0; nb = 0;
        configure(10'h300, 10'd0, 10'd0, 10'h300, 4'd2);
        bus.writes_en = 1'b1;
        for (int c = 0; c < 40 && !(sent == 5 && !bus.ib_valid); c++) begin
            tick();
            n_checks++; if (bus.ib_re !== e_ib_re) begin n_errors++; $display("FAIL drain_ib_re cyc %0d got %b want %b", c, bus.ib_re, e_ib_re); end
            if (bus.ib_re && sent < 5) begin
                bus.ib_valid = 1'b1;
                bus.ib_data = 16'(16'h00A0 + sent);
                sent++;
            end else begin
                bus.ib_valid = 1'b0;
            end
        end
        bus.writes_en = 1'b0;
        bus.ib_valid = 1'b0;
        n_checks++; if (sent !== 5) begin n_errors++; $display("FAIL drain_timeout got %0d pops want 5", sent); end
        tick();
        n_checks++; if (wr_count !== 16'd5) begin n_errors++; $display("FAIL drain_wr_count got %0d want 5", wr_count); end
        n_checks++; if (wr_err !== 1'b0) begin n_errors++; $display("FAIL drain_wr_err got %b want 0", wr_err); end
        configure(10'h300, 10'd0, 10'd0, 10'h000, 4'd0);
        bus.reads_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== 16'(16'h00A0 + c)) begin n_errors++; $display("FAIL drain_readback %0d got %b/%h want 1/%h", c, bus.ob_we, bus.ob_data, 16'(16'h00A0 + c)); end
        end
        bus.reads_en = 1'b0;
    endtask

    task automatic test_wrap_collision();
        logic [15:0] dl, d1, d2;
        configure(10'h3FE, 10'd0, 10'd0, 10'h3FF, 4'd0);
        bus.reads_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (bus.ob_data !== shadow[10'((16'h3FE + c) & 1023)]) begin n_errors++; $display("FAIL wrap_read %0d got %h want %h", c, bus.ob_data, shadow[10'((16'h3FE + c) & 1023)]); end
        end
        bus.reads_en = 1'b0;
        dl = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
        ld_we = 1'b1; ld_addr = 10'h100; ld_data = dl;
        bus.ib_valid = 1'b1; bus.ib_data = ~dl;
        tick();
        ld_we = 1'b0;
        n_checks++; if (wr_count !== 16'd0) begin n_errors++; $display("FAIL collide_wr_count got %0d want 0", wr_count); end
        n_checks++; if (wr_err !== 1'b1) begin n_errors++; $display("FAIL collide_wr_err got %b want 1", wr_err); end
        bus.ib_data = d1;
        tick();
        bus.ib_data = d2;
        tick();
        bus.ib_valid = 1'b0;
        n_checks++; if (wr_count !== 16'd2) begin n_errors++; $display("FAIL wrwrap_wr_count got %0d want 2", wr_count); end
        n_checks++; if (wr_err !== 1'b1) begin n_errors++; $display("FAIL sticky_wr_err got %b want 1", wr_err); end
        configure(10'h3FF, 10'd0, 10'd0, 10'h000, 4'd0);
        bus.reads_en = 1'b1;
        tick();
        n_checks++; if (bus.ob_data !== d1) begin n_errors++; $display("FAIL wrwrap_3ff got %h want %h", bus.ob_data, d1); end
        tick();
        n_checks++; if (bus.ob_data !== d2) begin n_errors++; $display("FAIL wrwrap_000 got %h want %h", bus.ob_data, d2); end
        bus.reads_en = 1'b0;
        configure(10'h100, 10'd0, 10'd0, 10'h000, 4'd0);
        bus.reads_en = 1'b1;
        tick();
        n_checks++; if (bus.ob_data !== dl) begin n_errors++; $display("FAIL collide_preload got %h want %h", bus.ob_data, dl); end
        bus.reads_en = 1'b0;
    endtask

    task automatic test_reconfig();
        configure(10'h010, 10'd0, 10'd0, 10'h000, 4'd2);
        bus.reads_en = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        // the next edge would be a beat; the config must win it
        cfg_rd_base = 10'h020; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (bus.ob_we !== 1'b0) begin n_errors++; $display("FAIL reconfig_ob_we got %b want 0", bus.ob_we); end
        n_checks++; if (rd_count !== 16'd0) begin n_errors++; $display("FAIL reconfig_rd_count got %0d want 0", rd_count); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++; if (bus.ob_we !== (c == 3)) begin n_errors++; $display("FAIL reconfig_latency cyc %0d got %b want %b", c, bus.ob_we, c == 3); end
        end
        n_checks++; if (bus.ob_data !== shadow[10'h020]) begin n_errors++; $display("FAIL reconfig_data got %h want %h", bus.ob_data, shadow[10'h020]); end
        bus.reads_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            configure(10'($urandom), 10'($urandom_range(20, 0)), 10'($urandom_range(7, 0)),
                      10'($urandom), 4'($urandom_range(5, 0)));
            for (int c = 0; c < 150; c++) begin
                bus.reads_en  = ($urandom_range(3, 0) != 0);
                bus.writes_en = ($urandom_range(1, 0) != 0);
                bus.ib_valid  = ($urandom_range(2, 0) == 0);
                bus.ib_data   = 16'($urandom);
                ld_we   = ($urandom_range(15, 0) == 0);
                ld_addr = 10'($urandom);
                ld_data = 16'($urandom);
                rst = (r == 3 && c == 75);
                tick();
                n_checks++; if (bus.ob_we !== e_ob_we) begin n_errors++; $display("FAIL rand_ob_we r%0d c%0d got %b want %b", r, c, bus.ob_we, e_ob_we); end
                n_checks++; if (bus.ob_data !== e_ob_data) begin n_errors++; $display("FAIL rand_ob_data r%0d c%0d got %h want %h", r, c, bus.ob_data, e_ob_data); end
                n_checks++; if (bus.ib_re !== e_ib_re) begin n_errors++; $display("FAIL rand_ib_re r%0d c%0d got %b want %b", r, c, bus.ib_re, e_ib_re); end
                n_checks++; if (rd_count !== e_rd || wr_count !== e_wr) begin n_errors++; $display("FAIL rand_counts r%0d c%0d got %0d/%0d want %0d/%0d", r, c, rd_count, wr_count, e_rd, e_wr); end
                n_checks++; if (wr_err !== e_err) begin n_errors++; $display("FAIL rand_wr_err r%0d c%0d got %b want %b", r, c, wr_err, e_err); end
            end
            rst = 1'b0; ld_we = 1'b0;
            bus.reads_en = 1'b0; bus.writes_en = 1'b0; bus.ib_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; ld_we = 1'b0;
        cfg_rd_base = '0; cfg_win_len = '0; cfg_win_step = '0; cfg_wr_base = '0; cfg_gap = '0;
        ld_addr = '0; ld_data = '0;
        bus.reads_en = 1'b0; bus.writes_en = 1'b0; bus.ib_valid = 1'b0; bus.ib_data = '0;
        #2;
        test_reset();
        preload_all();
        test_linear();
        test_window();
        test_pause();
        test_drain();
        test_wrap_collision();
        test_reconfig();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dma_port_model.md
# dma_port_model

Parametrised, synthesizable DMA port responder that stands in for one read port and one write port of the memory-side DMA when engine ops are exercised in isolation. It holds a local memory preloaded by the bench and streams it to the engine with a programmable beat cadence and sliding-window rewind, which is the access pattern CMAC data reads need. It also drains engine results through the `ib_re`/`ib_valid` handshake into the same memory. One instance replaces each hand-written per-port stimulus process.

## Interface
- `DATA_W`, 16: beat width.
- `ADDR_W`, 10: memory address width; depth = 2**ADDR_W words.
- `GAP_W`, 4: width of the cadence configuration field.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_valid`  in  1: one-cycle pulse; loads all `cfg_*` fields.
- `cfg_rd_base`  in  ADDR_W: first read address.
- `cfg_win_len`  in  ADDR_W: beats per window; 0 = linear (no rewind).
- `cfg_win_step`  in  ADDR_W: window start advance on rewind.
- `cfg_wr_base`  in  ADDR_W: first write address.
- `cfg_gap`  in  GAP_W: idle cycles between beats; the period is `cfg_gap`+1.
- `ld_we`  in  1: bench preload write strobe.
- `ld_addr`  in  ADDR_W: bench preload address.
- `ld_data`  in  DATA_W: bench preload data.
- `reads_en`  in  1: engine read request (level).
- `ob_we`  out  1: one-cycle beat strobe to the engine.
- `ob_data`  out  DATA_W: beat data, valid while `ob_we` is high.
- `writes_en`  in  1: engine write request (level).
- `ib_re`  out  1: one-cycle pop strobe to the engine result buffer.
- `ib_valid`  in  1: engine result word present on `ib_data`.
- `ib_data`  in  DATA_W: engine result word.
- `rd_count`  out  16: beats issued since config.
- `wr_count`  out  16: words captured since config.
- `wr_err`  out  1: sticky flag; an `ib` write was lost to a preload collision.

## Operation
- Memory is a register array with combinational read. Contents are not cleared by `rst` or `cfg_valid`.
- The read engine has a phase counter `rph` in 0..`cfg_gap`.
  - While `reads_en` is high, `rph` increments and wraps to 0 after reaching `cfg_gap`.
  - While `reads_en` is low, `rph` holds and `ob_we` is 0. A deasserted request pauses the stream; it does not restart it.
  - A beat fires on the cycle where `reads_en` is high and `rph` equals `cfg_gap`. On that edge: `ob_we` is set to 1, `ob_data` is set to `mem[rd_ptr]`, the pointer advances, and `rd_count` increments. On any other cycle `ob_we` is 0 and `ob_data` holds its value.
- Pointer advance:
  - Linear (`cfg_win_len`=0): `rd_ptr` becomes `rd_ptr`+1.
  - Window mode: `win_cnt` counts beats within the window. On the beat where `win_cnt` equals `cfg_win_len`-1:
    - `win_start` becomes `win_start`+`cfg_win_step`;
    - `rd_ptr` is set to that new `win_start`;
    - `win_cnt` is set to 0.
  - Otherwise `rd_ptr` becomes `rd_ptr`+1 and `win_cnt` becomes `win_cnt`+1.
- All address arithmetic is ADDR_W bits and wraps modulo the depth.
- The write engine uses the same cadence with its own phase counter `wph`, gated by `writes_en`. `ib_re` pulses for one cycle when `wph` equals `cfg_gap`.
- Capture is independent of `ib_re`. Any cycle with `ib_valid` high writes `ib_data` to `mem[wr_ptr]`, then `wr_ptr` increments (wrapping) and `wr_count` increments.
- Collision: if `ld_we` and `ib_valid` are high on the same cycle, the preload wins. The `ib` word is dropped, `wr_ptr` and `wr_count` do not advance, and `wr_err` is set to 1.
- `cfg_valid` resets state and loads config:
  - it sets `rd_ptr`=`win_start`=`cfg_rd_base`, `wr_ptr`=`cfg_wr_base`, and clears `win_cnt`, `rph`, `wph`, both counts and `wr_err`;
  - it forces `ob_we` and `ib_re` to 0 that cycle;
  - it takes priority over a beat or capture on the same cycle, including mid-stream.
- `rd_count` and `wr_count` saturate at 16'hFFFF.

## Timing
- Reset values: `ob_we`=0, `ob_data`=0, `ib_re`=0, `rd_count`=0, `wr_count`=0, `wr_err`=0. Internal pointers, phases and config all reset to 0.
- Reset applied mid-stream aborts the stream on the next edge.
- Beat latency: with `reads_en` rising at edge E from `rph`=0, the first `ob_we` appears at edge E+`cfg_gap`. Subsequent beats follow every `cfg_gap`+1 cycles.
- `cfg_gap`=0 gives one beat per cycle.
- Preload writes take effect at the edge. A read of the same address on the following beat sees the new data.
- A capture at edge E is readable by a beat at edge E+1.

## Test plan
- Linear stream: preload mem[i]=16'h3C00+i; configure base=0, gap=2, win_len=0; hold `reads_en` high. Expect `ob_we` every 3rd cycle with data 3C00, 3C01, 3C02, …, and `rd_count`=10 after 30 cycles.
- Sliding window: base=0, win_len=45, step=1, gap=2. Expect beat addresses 0..44, then 1..45, then 2..46. `win_cnt` resets at each rewind.
- Pause: drop `reads_en` for 7 cycles in mid-stream. Expect no `ob_we` during the gap; the stream resumes with the next address and the phase kept (no skipped or duplicated beat).
- Drain: wr_base=0x300, gap=2. Drive `ib_valid` one cycle after each `ib_re`, with data A0..A4. Expect mem[0x300..0x304]=A0..A4, `wr_count`=5, `wr_err`=0.
- Wrap and collision:
  - base=0x3FE with ADDR_W=10: expect addresses 0x3FE, 0x3FF, 0x000.
  - Pulse `ld_we` together with `ib_valid`: expect the preload data stored, `wr_count` unchanged, `wr_err`=1.
- Reconfigure mid-stream: assert `cfg_valid` with a new base while `reads_en` is high. Expect `ob_we`=0 that cycle, counts cleared, and the next beat `cfg_gap`+1 cycles later from the new base.
